// File: rtl/combat_resolver.sv
// Frame-synchronous two-player hit resolver: hitbox overlap, one hit per attack
// instance, saturating health, chip damage, hitstun and KO/winner latching.

module combat_attack #(
  parameter int POS_WIDTH    = 10,
  parameter int NUM_HITBOXES = 2,
  parameter int HP_WIDTH     = 8,
  parameter int DMG_ATK1     = 8,
  parameter int DMG_ATK2     = 12,
  parameter int CHIP_DMG     = 1
) (
  input  logic [2:0]                        atk_action_i,
  input  logic [2:0]                        dfd_action_i,
  input  logic [NUM_HITBOXES*POS_WIDTH-1:0] hit_left_i,
  input  logic [NUM_HITBOXES*POS_WIDTH-1:0] hit_right_i,
  input  logic [NUM_HITBOXES-1:0]           hit_valid_i,
  input  logic [POS_WIDTH-1:0]              hurt_left_i,
  input  logic [POS_WIDTH-1:0]              hurt_right_i,
  input  logic                              conn_i,
  input  logic [2:0]                        code_i,
  input  logic                              dfd_stunned_i,
  input  logic                              round_over_i,
  output logic                              block_o,
  output logic                              hit_o,
  output logic [HP_WIDTH-1:0]               dmg_o,
  output logic                              conn_d_o,
  output logic [2:0]                        code_d_o
);
  localparam logic [2:0] ACT_BLOCK = 3'b011;
  localparam logic [2:0] ACT_ATK1  = 3'b100;
  localparam logic [2:0] ACT_ATK2  = 3'b101;
  localparam logic [HP_WIDTH-1:0] D1 = HP_WIDTH'(DMG_ATK1);
  localparam logic [HP_WIDTH-1:0] D2 = HP_WIDTH'(DMG_ATK2);
  localparam logic [HP_WIDTH-1:0] DC = HP_WIDTH'(CHIP_DMG);

  logic [NUM_HITBOXES-1:0] box_ov;
  logic overlap, is_atk, clear, land;

  for (genvar i = 0; i < NUM_HITBOXES; i++) begin : g_box
    assign box_ov[i] = hit_valid_i[i]
                    && (hit_left_i[i*POS_WIDTH +: POS_WIDTH]  <= hurt_right_i)
                    && (hit_right_i[i*POS_WIDTH +: POS_WIDTH] >= hurt_left_i);
  end

  assign overlap = |box_ov;
  assign is_atk  = (atk_action_i == ACT_ATK1) || (atk_action_i == ACT_ATK2);
  // Leaving the attack, or switching to a different one, re-arms the attacker.
  assign clear   = conn_i && (!is_atk || (atk_action_i != code_i));
  // A stunned defender defers the hit without consuming the attack instance.
  assign land    = is_atk && overlap && !conn_i && !dfd_stunned_i && !round_over_i;
  assign block_o = land && (dfd_action_i == ACT_BLOCK);
  assign hit_o   = land && (dfd_action_i != ACT_BLOCK);

  always_comb begin
    dmg_o = '0;
    if (block_o)    dmg_o = DC;
    else if (hit_o) dmg_o = (atk_action_i == ACT_ATK1) ? D1 : D2;
  end

  assign conn_d_o = land ? 1'b1 : (clear ? 1'b0 : conn_i);
  assign code_d_o = land ? atk_action_i : code_i;
endmodule

module combat_resolver #(
  parameter int POS_WIDTH      = 10,
  parameter int NUM_HITBOXES   = 2,
  parameter int HP_WIDTH       = 8,
  parameter int MAX_HP         = 100,
  parameter int DMG_ATK1       = 8,
  parameter int DMG_ATK2       = 12,
  parameter int CHIP_DMG       = 1,
  parameter int HITSTUN_FRAMES = 12
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              frame_tick,
  input  logic                              round_start,
  input  logic [2:0]                        p1_action,
  input  logic [2:0]                        p2_action,
  input  logic [NUM_HITBOXES*POS_WIDTH-1:0] p1_hit_left,
  input  logic [NUM_HITBOXES*POS_WIDTH-1:0] p1_hit_right,
  input  logic [NUM_HITBOXES*POS_WIDTH-1:0] p2_hit_left,
  input  logic [NUM_HITBOXES*POS_WIDTH-1:0] p2_hit_right,
  input  logic [NUM_HITBOXES-1:0]           p1_hit_valid,
  input  logic [NUM_HITBOXES-1:0]           p2_hit_valid,
  input  logic [POS_WIDTH-1:0]              p1_hurt_left,
  input  logic [POS_WIDTH-1:0]              p1_hurt_right,
  input  logic [POS_WIDTH-1:0]              p2_hurt_left,
  input  logic [POS_WIDTH-1:0]              p2_hurt_right,
  output logic                              hit_p1_to_p2,
  output logic                              hit_p2_to_p1,
  output logic                              block_p1,
  output logic                              block_p2,
  output logic [HP_WIDTH-1:0]               p1_health,
  output logic [HP_WIDTH-1:0]               p2_health,
  output logic                              p1_stunned,
  output logic                              p2_stunned,
  output logic                              round_over,
  output logic [1:0]                        winner
);
  localparam logic [HP_WIDTH-1:0] HP_INIT = HP_WIDTH'(MAX_HP);
  localparam logic [7:0]          STUN    = 8'(HITSTUN_FRAMES);

  logic [HP_WIDTH-1:0] p1_hp_q, p2_hp_q, p1_hp_d, p2_hp_d;
  logic [HP_WIDTH:0]   p1_diff, p2_diff;
  logic [7:0]          p1_stun_q, p2_stun_q, p1_stun_d, p2_stun_d;
  logic                p1_conn_q, p2_conn_q;
  logic [2:0]          p1_code_q, p2_code_q;
  logic                hit12_q, hit21_q, blk1_q, blk2_q;
  logic                p1_stn_q, p2_stn_q, over_q;
  logic [1:0]          winner_q;
  logic                ko_p1, ko_p2;

  // a1: P1 attacking P2, a2: P2 attacking P1
  logic                a1_block, a1_hit, a1_conn_d, a2_block, a2_hit, a2_conn_d;
  logic [HP_WIDTH-1:0] a1_dmg, a2_dmg;
  logic [2:0]          a1_code_d, a2_code_d;

  combat_attack #(
    .POS_WIDTH(POS_WIDTH), .NUM_HITBOXES(NUM_HITBOXES), .HP_WIDTH(HP_WIDTH),
    .DMG_ATK1(DMG_ATK1), .DMG_ATK2(DMG_ATK2), .CHIP_DMG(CHIP_DMG)
  ) u_a1 (
    .atk_action_i(p1_action), .dfd_action_i(p2_action),
    .hit_left_i(p1_hit_left), .hit_right_i(p1_hit_right), .hit_valid_i(p1_hit_valid),
    .hurt_left_i(p2_hurt_left), .hurt_right_i(p2_hurt_right),
    .conn_i(p1_conn_q), .code_i(p1_code_q), .dfd_stunned_i(p2_stun_q != 8'd0),
    .round_over_i(over_q), .block_o(a1_block), .hit_o(a1_hit), .dmg_o(a1_dmg),
    .conn_d_o(a1_conn_d), .code_d_o(a1_code_d)
  );

  combat_attack #(
    .POS_WIDTH(POS_WIDTH), .NUM_HITBOXES(NUM_HITBOXES), .HP_WIDTH(HP_WIDTH),
    .DMG_ATK1(DMG_ATK1), .DMG_ATK2(DMG_ATK2), .CHIP_DMG(CHIP_DMG)
  ) u_a2 (
    .atk_action_i(p2_action), .dfd_action_i(p1_action),
    .hit_left_i(p2_hit_left), .hit_right_i(p2_hit_right), .hit_valid_i(p2_hit_valid),
    .hurt_left_i(p1_hurt_left), .hurt_right_i(p1_hurt_right),
    .conn_i(p2_conn_q), .code_i(p2_code_q), .dfd_stunned_i(p1_stun_q != 8'd0),
    .round_over_i(over_q), .block_o(a2_block), .hit_o(a2_hit), .dmg_o(a2_dmg),
    .conn_d_o(a2_conn_d), .code_d_o(a2_code_d)
  );

  always_comb begin
    p1_diff   = {1'b0, p1_hp_q} - {1'b0, a2_dmg};
    p2_diff   = {1'b0, p2_hp_q} - {1'b0, a1_dmg};
    p1_hp_d   = p1_diff[HP_WIDTH] ? '0 : p1_diff[HP_WIDTH-1:0];
    p2_hp_d   = p2_diff[HP_WIDTH] ? '0 : p2_diff[HP_WIDTH-1:0];
    p1_stun_d = a2_hit ? STUN : ((p1_stun_q != 8'd0) ? p1_stun_q - 8'd1 : 8'd0);
    p2_stun_d = a1_hit ? STUN : ((p2_stun_q != 8'd0) ? p2_stun_q - 8'd1 : 8'd0);
    ko_p1     = (p1_hp_d == '0);
    ko_p2     = (p2_hp_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst || round_start) begin
      p1_hp_q   <= HP_INIT;
      p2_hp_q   <= HP_INIT;
      p1_stun_q <= '0;
      p2_stun_q <= '0;
      p1_stn_q  <= 1'b0;
      p2_stn_q  <= 1'b0;
      p1_conn_q <= 1'b0;
      p2_conn_q <= 1'b0;
      p1_code_q <= '0;
      p2_code_q <= '0;
      hit12_q   <= 1'b0;
      hit21_q   <= 1'b0;
      blk1_q    <= 1'b0;
      blk2_q    <= 1'b0;
      over_q    <= 1'b0;
      winner_q  <= '0;
    end else begin
      hit12_q <= 1'b0;
      hit21_q <= 1'b0;
      blk1_q  <= 1'b0;
      blk2_q  <= 1'b0;
      if (frame_tick) begin
        p1_hp_q   <= p1_hp_d;
        p2_hp_q   <= p2_hp_d;
        p1_stun_q <= p1_stun_d;
        p2_stun_q <= p2_stun_d;
        p1_stn_q  <= (p1_stun_d != 8'd0);
        p2_stn_q  <= (p2_stun_d != 8'd0);
        p1_conn_q <= a1_conn_d;
        p2_conn_q <= a2_conn_d;
        p1_code_q <= a1_code_d;
        p2_code_q <= a2_code_d;
        hit12_q   <= a1_hit;
        hit21_q   <= a2_hit;
        blk2_q    <= a1_block;
        blk1_q    <= a2_block;
        if (!over_q && (ko_p1 || ko_p2)) begin
          over_q   <= 1'b1;
          winner_q <= {ko_p1, ko_p2};
        end
      end
    end
  end

  assign hit_p1_to_p2 = hit12_q;
  assign hit_p2_to_p1 = hit21_q;
  assign block_p1     = blk1_q;
  assign block_p2     = blk2_q;
  assign p1_health    = p1_hp_q;
  assign p2_health    = p2_hp_q;
  assign p1_stunned   = p1_stn_q;
  assign p2_stunned   = p2_stn_q;
  assign round_over   = over_q;
  assign winner       = winner_q;
endmodule
